box_renderer: RTL
=================

BOX_RENDERER -- requirements
Module: box_renderer

Interface
REQ-001 Parameter BOX, default 16: square side in pixels.
REQ-002 Parameter STEP, default 2: pixels moved per axis per motion update.
REQ-003 Parameter BOX_RGB, default 8'b111_000_00: box colour, packed {red, green, blue}.
REQ-004 Parameter BG_RGB, default 8'b000_000_10: background colour.
REQ-005 Port dclk, input, 1: pixel clock; one clock; all state on rising edge.
REQ-006 Port clr, input, 1: reset, synchronous, active-high.
REQ-007 Port hc, input, 10: horizontal pixel counter from the timing generator, 0..799.
REQ-008 Port vc, input, 10: vertical line counter from the timing generator, 0..520.
REQ-009 Port hsync_in / vsync_in, input, 1 each: active-low syncs from the timing generator.
REQ-010 Port pause, input, 1: high freezes motion.
REQ-011 Port speed, input, 2: motion update every speed+1 frames.
REQ-012 Port red, output, 3 / green, output, 3 / blue, output, 2: registered pixel colour.
REQ-013 Port hsync / vsync, output, 1 each: syncs delayed to align with colour.

Function
REQ-014 Visible region SHALL be hc < ha (640) and vc < va (480); all other positions are blanking.
REQ-015 Colour outputs SHALL have 1-cycle latency from hc/vc; hsync/vsync SHALL be hsync_in/vsync_in delayed by exactly 1 cycle.
REQ-016 In blanking, {red,green,blue} SHALL be 0.
REQ-017 Visible pixel priority: inside box (x <= hc < x+BOX and y <= vc < y+BOX) -> BOX_RGB; else frame border (hc==0, hc==639, vc==0 or vc==479) -> 8'hFF; else BG_RGB.
REQ-018 Update strobe SHALL be the single cycle with hc==0 and vc==480 (start of vertical blanking); x/y SHALL change only on that cycle, never during visible lines.
REQ-019 Frame counter fcnt (2 bits): on strobe with pause low, if fcnt==speed then fcnt<=0 and a motion step occurs, else fcnt<=fcnt+1.
REQ-020 Motion step, horizontal: dx=1 and x+STEP >= 640-BOX -> x<=640-BOX, dx<=0; dx=0 and x <= STEP -> x<=0, dx<=1; otherwise x<=x±STEP.
REQ-021 Vertical SHALL follow REQ-020 with y, dy and limit 480-BOX.
REQ-022 Both axes SHALL be evaluated in the same cycle; a corner hit reverses dx and dy together.
REQ-023 pause high on the strobe SHALL hold x, y, dx, dy and fcnt; pause has no effect off-strobe.
REQ-024 speed changes SHALL take effect at the next strobe; if fcnt > new speed, fcnt SHALL wrap to 0 with a motion step.
REQ-025 Arithmetic SHALL be 11-bit unsigned internally; no underflow or overflow is permitted at the bounds.

Reset
REQ-026 On clr high at a dclk edge: x<=312, y<=232, dx<=1, dy<=1, fcnt<=0.
REQ-027 On the same edge: red/green/blue<=0 and hsync/vsync<=1 (inactive).
REQ-028 Reset asserted mid-frame SHALL blank output on the next cycle; rendering resumes 1 cycle after release, with no strobe required.

Structure
REQ-029 Timing constants (ha, hfp, hp, hpixels, va, vfp, vp, vlines) SHALL come from the shared definitions include; no local redefinition.
REQ-030 Screen limits SHALL derive from ha/va: 640-BOX = ha-BOX, 480-BOX = va-BOX.
REQ-031 Sub-module box_motion SHALL hold x, y, dx, dy and fcnt, with inputs strobe, pause and speed; box_renderer holds the pixel and sync output registers.

Verification
REQ-032 Reset, then one frame with pause=0 and speed=0 -> after the strobe, x=314, y=234.
REQ-033 Force x=622, dx=1 via ~155 steps -> next step gives x=624, dx=0; following step gives x=622.
REQ-034 Corner: x=2, y=2, dx=0, dy=0 at strobe -> x=0, y=0, dx=1, dy=1 in the same cycle.
REQ-035 speed=3 for 8 frames -> exactly 2 motion steps; pause=1 for 3 frames -> x, y and fcnt unchanged.
REQ-036 Pixel check: hc=312, vc=232 after reset -> next cycle {r,g,b}=BOX_RGB; hc=0, vc=100 -> 8'hFF; hc=700 -> 0; hsync equals hsync_in delayed 1 cycle throughout.

Source files
------------

// File: rtl/box_renderer_pkg.sv
// Shared definitions for the bouncing-box renderer: VGA 640x480 timing
// constants, coordinate and colour types, and the per-axis motion state.
package box_renderer_pkg;

  localparam int ha      = 640;
  localparam int hfp     = 16;
  localparam int hp      = 96;
  localparam int hpixels = 800;
  localparam int va      = 480;
  localparam int vfp     = 10;
  localparam int vp      = 2;
  localparam int vlines  = 521;

  // 11 bits keeps x+BOX and y+BOX representable at the far screen edge.
  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [7:0]         rgb_t;

  localparam rgb_t BORDER_RGB = 8'hFF;

  // Position plus direction (1 = increasing) for one axis.
  typedef struct packed {
    coord_t pos;
    logic   dir;
  } axis_t;

endpackage

// File: rtl/box_renderer_if.sv
// Pixel bus between the timing generator and the box renderer: counters and
// raw syncs in, registered colour and aligned syncs out, plus motion controls.
interface box_renderer_if;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       hsync_in;
  logic       vsync_in;
  logic       pause;
  logic [1:0] speed;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       hsync;
  logic       vsync;

  modport master (
    output hc, vc, hsync_in, vsync_in, pause, speed,
    input  red, green, blue, hsync, vsync
  );

  modport slave (
    input  hc, vc, hsync_in, vsync_in, pause, speed,
    output red, green, blue, hsync, vsync
  );
endinterface

// File: rtl/box_renderer_motion.sv
// Box position state: advances x/y by STEP once every speed+1 update strobes
// and reflects off the screen edges, clamping so nothing wraps.
module box_motion
  import box_renderer_pkg::*;
#(
  parameter int BOX  = 16,
  parameter int STEP = 2
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       i_strobe,
  input  logic       i_pause,
  input  logic [1:0] i_speed,
  output coord_t     o_x,
  output coord_t     o_y
);

  localparam coord_t XLIM   = coord_t'(ha - BOX);
  localparam coord_t YLIM   = coord_t'(va - BOX);
  localparam coord_t STEP_C = coord_t'(STEP);

  // One motion step on one axis; at a bound the position is clamped and the
  // direction flips in the same update.
  function automatic axis_t axis_step(input axis_t a, input coord_t lim);
    axis_t n;
    n = a;
    if (a.dir) begin
      if (a.pos + STEP_C >= lim) begin
        n.pos = lim;
        n.dir = 1'b0;
      end else begin
        n.pos = a.pos + STEP_C;
      end
    end else begin
      if (a.pos <= STEP_C) begin
        n.pos = '0;
        n.dir = 1'b1;
      end else begin
        n.pos = a.pos - STEP_C;
      end
    end
    return n;
  endfunction

  coord_t     r_x;
  coord_t     r_y;
  logic       r_dx;
  logic       r_dy;
  logic [1:0] r_fcnt;
  axis_t      w_xn;
  axis_t      w_yn;

  assign w_xn = axis_step({r_x, r_dx}, XLIM);
  assign w_yn = axis_step({r_y, r_dy}, YLIM);
  assign o_x  = r_x;
  assign o_y  = r_y;

  // Frame divider and motion update; ">=" also wraps a stale fcnt after speed drops.
  always_ff @(posedge dclk) begin
    if (clr) begin
      r_x    <= 11'd312;
      r_y    <= 11'd232;
      r_dx   <= 1'b1;
      r_dy   <= 1'b1;
      r_fcnt <= 2'd0;
    end else if (i_strobe && !i_pause) begin
      if (r_fcnt >= i_speed) begin
        r_fcnt <= 2'd0;
        r_x    <= w_xn.pos;
        r_dx   <= w_xn.dir;
        r_y    <= w_yn.pos;
        r_dy   <= w_yn.dir;
      end else begin
        r_fcnt <= r_fcnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/box_renderer.sv
// Bouncing-box renderer: paints a BOX-sized square, a white frame border and
// a background colour, with one register stage on colour and syncs.
module box_renderer
  import box_renderer_pkg::*;
#(
  parameter int   BOX     = 16,
  parameter int   STEP    = 2,
  parameter rgb_t BOX_RGB = 8'b111_000_00,
  parameter rgb_t BG_RGB  = 8'b000_000_10
) (
  input logic           dclk,
  input logic           clr,
  box_renderer_if.slave vga
);

  localparam coord_t BOX_C = coord_t'(BOX);
  localparam coord_t HA_C  = coord_t'(ha);
  localparam coord_t VA_C  = coord_t'(va);
  localparam coord_t HLAST = coord_t'(ha - 1);
  localparam coord_t VLAST = coord_t'(va - 1);

  coord_t w_hc;
  coord_t w_vc;
  coord_t w_x;
  coord_t w_y;
  logic   w_strobe;
  logic   w_visible;
  logic   w_in_box;
  logic   w_border;
  rgb_t   w_pix;

  rgb_t   r_rgb_p1;
  logic   r_hsync_p1;
  logic   r_vsync_p1;

  assign w_hc = {1'b0, vga.hc};
  assign w_vc = {1'b0, vga.vc};

  // First pixel of vertical blanking: the only point where the box may move.
  assign w_strobe  = (w_hc == '0) && (w_vc == VA_C);
  assign w_visible = (w_hc < HA_C) && (w_vc < VA_C);
  assign w_in_box  = (w_hc >= w_x) && (w_hc < w_x + BOX_C) &&
                     (w_vc >= w_y) && (w_vc < w_y + BOX_C);
  assign w_border  = (w_hc == '0) || (w_hc == HLAST) ||
                     (w_vc == '0) || (w_vc == VLAST);

  box_motion #(
    .BOX  (BOX),
    .STEP (STEP)
  ) u_motion (
    .dclk     (dclk),
    .clr      (clr),
    .i_strobe (w_strobe),
    .i_pause  (vga.pause),
    .i_speed  (vga.speed),
    .o_x      (w_x),
    .o_y      (w_y)
  );

  // Pixel colour select: blanking, then box, then border, then background.
  always_comb begin
    w_pix = '0;
    if (w_visible) begin
      if (w_in_box)      w_pix = BOX_RGB;
      else if (w_border) w_pix = BORDER_RGB;
      else               w_pix = BG_RGB;
    end
  end

  // Output stage: colour and syncs registered together so they stay aligned.
  always_ff @(posedge dclk) begin
    if (clr) begin
      r_rgb_p1   <= '0;
      r_hsync_p1 <= 1'b1;
      r_vsync_p1 <= 1'b1;
    end else begin
      r_rgb_p1   <= w_pix;
      r_hsync_p1 <= vga.hsync_in;
      r_vsync_p1 <= vga.vsync_in;
    end
  end

  assign vga.red   = r_rgb_p1[7:5];
  assign vga.green = r_rgb_p1[4:2];
  assign vga.blue  = r_rgb_p1[1:0];
  assign vga.hsync = r_hsync_p1;
  assign vga.vsync = r_vsync_p1;

endmodule
